core_amo_unit: RTL and testbench
================================

// Module: core_amo_unit
// PURPOSE
//  Memory-stage executor for RV64A instructions. Consumes the decoder's amo/amo_op/lr/sc/size
//  controls and runs an LR, SC or AMO read-modify-write sequence on the data-memory port.
//  Holds this core's LR/SC reservation and drops it on a coherence snoop from other cores.
//  Stalls the pipeline while busy and returns the rd writeback value.
// PARAMETERS
//  XLEN          64  data/address width
//  RSV_GRAN_LG2  3   log2 of the reservation granule in bytes; compare uses addr[XLEN-1:RSV_GRAN_LG2]
// PORTS
//  i_core_amo_unit_clk          in   1     clock
//  i_core_amo_unit_rst          in   1     synchronous reset, active-high
//  i_core_amo_unit_start        in   1     instr valid in MEM with amo|lr|sc set
//  i_core_amo_unit_amo          in   1     decoder amo flag
//  i_core_amo_unit_amo_op       in   4     0 swap,1 add,2 xor,3 and,4 or,5 min,6 max,7 minu,8 maxu
//  i_core_amo_unit_lr           in   1     load-reserved
//  i_core_amo_unit_sc           in   1     store-conditional
//  i_core_amo_unit_size         in   2     2'b10 word, 2'b11 doubleword
//  i_core_amo_unit_addr         in   XLEN  effective address (rs1)
//  i_core_amo_unit_src          in   XLEN  rs2 operand
//  o_core_amo_unit_busy         out  1     pipeline stall
//  o_core_amo_unit_done         out  1     1-cycle completion pulse
//  o_core_amo_unit_result       out  XLEN  rd value; valid only while done=1
//  o_core_amo_unit_misaligned   out  1     address-misaligned exception; qualified by done
//  o_core_amo_unit_req          out  1     memory request valid
//  i_core_amo_unit_gnt          in   1     memory accepts request
//  o_core_amo_unit_we           out  1     1 write, 0 read
//  o_core_amo_unit_maddr        out  XLEN  memory address
//  o_core_amo_unit_wdata        out  XLEN  write data, word ops in [31:0]
//  o_core_amo_unit_msize        out  2     copy of size
//  i_core_amo_unit_rvalid       in   1     response; read data, or write acknowledge
//  i_core_amo_unit_rdata        in   XLEN  read data
//  i_core_amo_unit_snoop_valid  in   1     another core wrote or invalidated a line
//  i_core_amo_unit_snoop_addr   in   XLEN  snooped address
// BEHAVIOUR
//  Reset: state IDLE, reservation invalid. req, we, done, busy, misaligned = 0; result, maddr, wdata = 0.
//  FSM: IDLE -> RD_REQ -> RD_WAIT -> [WR_REQ -> WR_WAIT] -> DONE -> IDLE.
//   IDLE accepts start; operands are latched on the accept cycle.
//   SC skips RD_*. LR skips WR_*. A failed SC or a misaligned access goes straight to DONE.
//  busy = (IDLE & start) | (state not in {IDLE, DONE}). done = 1 only in DONE. start is ignored outside IDLE.
//  Request rule: in *_REQ, req=1; we/maddr/wdata/msize stay stable until gnt.
//   On gnt go to *_WAIT, req=0. In *_WAIT, advance on rvalid.
//  Misaligned (addr[1:0]!=0 for word, addr[2:0]!=0 for dword): no memory access.
//   DONE the next cycle, misaligned=1, result=0, reservation unchanged.
//  LR: on rvalid set reservation valid with addr granule. result = rdata (word: sign-extend from bit 31).
//  SC: on the accept cycle, success iff reservation valid, granule matches, and no matching snoop that cycle.
//   Success -> write, result 0. Fail -> no access, result 1.
//   Reservation is cleared on the accept cycle in both cases.
//  AMO: latch old = rdata on rvalid and compute new in the same cycle.
//   Word ops use [31:0]; min/max are 32-bit signed, minu/maxu unsigned.
//   Write new value; result = old (word: sign-extend). An AMO whose granule matches the reservation clears it.
//  Snoop: a granule match clears the reservation in that cycle.
//   Snoop on the same cycle as LR's rvalid: snoop wins, reservation stays invalid.
//  Latency (gnt in same cycle as req, rvalid 1 cycle later), accept at T:
//   AMO done T+5; LR done T+3; SC success T+3; SC fail or misaligned done T+1.
//  Reset mid-operation: IDLE next cycle, req=0, reservation cleared. A late rvalid in IDLE is ignored.
// TESTING
//  amoadd.d addr 0x100, mem=5, src=3 -> write 8 to 0x100; result 5; done at T+5.
//  amomin.w addr 0x40, mem word 0xFFFFFFFF, src 1 -> writes 0xFFFFFFFF; result 0xFFFF_FFFF_FFFF_FFFF.
//  lr.d 0x200 (mem 7) -> result 7; sc.d 0x200 src 0xAB -> write 0xAB, result 0.
//   Second sc.d 0x200 -> result 1, req never asserted.
//  lr.d 0x200, snoop 0x204, sc.d 0x200 -> result 1, no write; same with snoop 0x208 -> SC succeeds.
//  amoswap.w addr 0x102 -> no req; done at T+1, misaligned=1, busy high only on the accept cycle.
//  lr.d 0x300, then amoor.d 0x300 with rst=1 during WR_REQ -> req=0 next cycle; following sc.d 0x300 result 1.

Source files
------------

// File: rtl/core_amo_unit.sv
// RV64A memory-stage executor: runs LR, SC and AMO read-modify-write sequences on the
// data-memory port and holds this core's LR/SC reservation, which coherence snoops can drop.
module core_amo_unit #(
  parameter int XLEN         = 64,
  parameter int RSV_GRAN_LG2 = 3
) (
  input  logic            i_core_amo_unit_clk,
  input  logic            i_core_amo_unit_rst,
  input  logic            i_core_amo_unit_start,
  input  logic            i_core_amo_unit_amo,
  input  logic [3:0]      i_core_amo_unit_amo_op,
  input  logic            i_core_amo_unit_lr,
  input  logic            i_core_amo_unit_sc,
  input  logic [1:0]      i_core_amo_unit_size,
  input  logic [XLEN-1:0] i_core_amo_unit_addr,
  input  logic [XLEN-1:0] i_core_amo_unit_src,
  output logic            o_core_amo_unit_busy,
  output logic            o_core_amo_unit_done,
  output logic [XLEN-1:0] o_core_amo_unit_result,
  output logic            o_core_amo_unit_misaligned,
  output logic            o_core_amo_unit_req,
  input  logic            i_core_amo_unit_gnt,
  output logic            o_core_amo_unit_we,
  output logic [XLEN-1:0] o_core_amo_unit_maddr,
  output logic [XLEN-1:0] o_core_amo_unit_wdata,
  output logic [1:0]      o_core_amo_unit_msize,
  input  logic            i_core_amo_unit_rvalid,
  input  logic [XLEN-1:0] i_core_amo_unit_rdata,
  input  logic            i_core_amo_unit_snoop_valid,
  input  logic [XLEN-1:0] i_core_amo_unit_snoop_addr
);

  localparam int GW = XLEN - RSV_GRAN_LG2;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE} state_t;

  state_t state, state_nxt;

  logic            lr_q;
  logic [3:0]      amo_op_q;
  logic [1:0]      size_q;
  logic [XLEN-1:0] src_q;
  logic [XLEN-1:0] maddr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] result_q;
  logic            we_q;
  logic            misaligned_q;
  logic            rsv_valid;
  logic [GW-1:0]   rsv_gran;

  logic            accept;
  logic            kind_lr;
  logic            kind_sc;
  logic            word_in;
  logic            misaligned_in;
  logic            snoop_hit;
  logic            sc_ok;
  logic            amo_rsv_hit;
  logic            lr_snoop_kill;
  logic [XLEN-1:0] src_fmt;

  logic            word_q;
  logic [XLEN-1:0] a_s, b_s, a_u, b_u;
  logic            lt_s, lt_u;
  logic [XLEN-1:0] new_val;
  logic [XLEN-1:0] new_fmt;

  logic            unused_snoop_bits;

  assign unused_snoop_bits = ^i_core_amo_unit_snoop_addr[RSV_GRAN_LG2-1:0];

  // The amo flag takes priority so a decoder quirk setting several flags still runs one sequence.
  assign accept        = (state == IDLE) && i_core_amo_unit_start;
  assign kind_lr       = !i_core_amo_unit_amo && i_core_amo_unit_lr;
  assign kind_sc       = !i_core_amo_unit_amo && !i_core_amo_unit_lr && i_core_amo_unit_sc;
  assign word_in       = (i_core_amo_unit_size == 2'b10);
  assign misaligned_in = word_in ? (i_core_amo_unit_addr[1:0] != 2'b00)
                                 : (i_core_amo_unit_addr[2:0] != 3'b000);
  assign snoop_hit     = rsv_valid && i_core_amo_unit_snoop_valid &&
                         (i_core_amo_unit_snoop_addr[XLEN-1:RSV_GRAN_LG2] == rsv_gran);
  assign sc_ok         = rsv_valid && !snoop_hit &&
                         (i_core_amo_unit_addr[XLEN-1:RSV_GRAN_LG2] == rsv_gran);
  assign amo_rsv_hit   = rsv_valid && (i_core_amo_unit_addr[XLEN-1:RSV_GRAN_LG2] == rsv_gran);
  assign lr_snoop_kill = i_core_amo_unit_snoop_valid &&
                         (i_core_amo_unit_snoop_addr[XLEN-1:RSV_GRAN_LG2] == maddr_q[XLEN-1:RSV_GRAN_LG2]);
  assign src_fmt       = word_in ? {{(XLEN-32){1'b0}}, i_core_amo_unit_src[31:0]}
                                 : i_core_amo_unit_src;
  assign word_q        = (size_q == 2'b10);

  // Word operands are sign-extended for signed compares and zero-extended for unsigned ones.
  always_comb begin
    a_s = word_q ? {{(XLEN-32){i_core_amo_unit_rdata[31]}}, i_core_amo_unit_rdata[31:0]}
                 : i_core_amo_unit_rdata;
    b_s = word_q ? {{(XLEN-32){src_q[31]}}, src_q[31:0]} : src_q;
    a_u = word_q ? {{(XLEN-32){1'b0}}, i_core_amo_unit_rdata[31:0]} : i_core_amo_unit_rdata;
    b_u = word_q ? {{(XLEN-32){1'b0}}, src_q[31:0]} : src_q;
    lt_s = $signed(a_s) < $signed(b_s);
    lt_u = a_u < b_u;
    case (amo_op_q)
      4'd1:    new_val = a_s + b_s;
      4'd2:    new_val = a_s ^ b_s;
      4'd3:    new_val = a_s & b_s;
      4'd4:    new_val = a_s | b_s;
      4'd5:    new_val = lt_s ? a_s : b_s;
      4'd6:    new_val = lt_s ? b_s : a_s;
      4'd7:    new_val = lt_u ? a_u : b_u;
      4'd8:    new_val = lt_u ? b_u : a_u;
      default: new_val = b_s;
    endcase
    new_fmt = word_q ? {{(XLEN-32){1'b0}}, new_val[31:0]} : new_val;
  end

  always_ff @(posedge i_core_amo_unit_clk) begin
    if (i_core_amo_unit_rst) state <= IDLE;
    else                     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_core_amo_unit_start) begin
          if (misaligned_in)   state_nxt = DONE;
          else if (kind_lr)    state_nxt = RD_REQ;
          else if (kind_sc)    state_nxt = sc_ok ? WR_REQ : DONE;
          else                 state_nxt = RD_REQ;
        end
      end
      RD_REQ:  if (i_core_amo_unit_gnt)    state_nxt = RD_WAIT;
      RD_WAIT: if (i_core_amo_unit_rvalid) state_nxt = lr_q ? DONE : WR_REQ;
      WR_REQ:  if (i_core_amo_unit_gnt)    state_nxt = WR_WAIT;
      WR_WAIT: if (i_core_amo_unit_rvalid) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands, memory-port registers and the reservation; later assignments override the snoop clear.
  always_ff @(posedge i_core_amo_unit_clk) begin
    if (i_core_amo_unit_rst) begin
      lr_q         <= 1'b0;
      amo_op_q     <= 4'd0;
      size_q       <= 2'b00;
      src_q        <= '0;
      maddr_q      <= '0;
      wdata_q      <= '0;
      result_q     <= '0;
      we_q         <= 1'b0;
      misaligned_q <= 1'b0;
      rsv_valid    <= 1'b0;
      rsv_gran     <= '0;
    end else begin
      if (snoop_hit) rsv_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            lr_q         <= kind_lr;
            amo_op_q     <= i_core_amo_unit_amo_op;
            size_q       <= i_core_amo_unit_size;
            src_q        <= i_core_amo_unit_src;
            maddr_q      <= i_core_amo_unit_addr;
            misaligned_q <= misaligned_in;
            we_q         <= kind_sc && sc_ok && !misaligned_in;
            wdata_q      <= kind_sc ? src_fmt : '0;
            result_q     <= (kind_sc && !misaligned_in && !sc_ok) ? {{(XLEN-1){1'b0}}, 1'b1} : '0;
            if (!misaligned_in && (kind_sc || (!kind_lr && amo_rsv_hit))) rsv_valid <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (i_core_amo_unit_rvalid) begin
            result_q <= a_s;
            if (lr_q) begin
              if (!lr_snoop_kill) begin
                rsv_valid <= 1'b1;
                rsv_gran  <= maddr_q[XLEN-1:RSV_GRAN_LG2];
              end
            end else begin
              wdata_q <= new_fmt;
              we_q    <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_core_amo_unit_busy       = accept || ((state != IDLE) && (state != DONE));
  assign o_core_amo_unit_done       = (state == DONE);
  assign o_core_amo_unit_result     = result_q;
  assign o_core_amo_unit_misaligned = misaligned_q && (state == DONE);
  assign o_core_amo_unit_req        = (state == RD_REQ) || (state == WR_REQ);
  assign o_core_amo_unit_we         = we_q;
  assign o_core_amo_unit_maddr      = maddr_q;
  assign o_core_amo_unit_wdata      = wdata_q;
  assign o_core_amo_unit_msize      = size_q;

endmodule

// File: tb/tb_core_amo_unit.sv
// Directed bench for core_amo_unit: a small memory responder plus a queue of expected
// completions (result, misaligned flag, latency) checked whenever done pulses.
module tb_core_amo_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, amo, lr, sc;
  logic [3:0]  amo_op;
  logic [1:0]  size;
  logic [63:0] addr, src;
  logic        busy, done, misaligned, req, we;
  logic [63:0] result, maddr, wdata;
  logic [1:0]  msize;
  logic        gnt;
  logic        rvalid;
  logic [63:0] rdata;
  logic        snoop_valid;
  logic [63:0] snoop_addr;

  core_amo_unit dut (
    .i_core_amo_unit_clk        (clk),
    .i_core_amo_unit_rst        (rst),
    .i_core_amo_unit_start      (start),
    .i_core_amo_unit_amo        (amo),
    .i_core_amo_unit_amo_op     (amo_op),
    .i_core_amo_unit_lr         (lr),
    .i_core_amo_unit_sc         (sc),
    .i_core_amo_unit_size       (size),
    .i_core_amo_unit_addr       (addr),
    .i_core_amo_unit_src        (src),
    .o_core_amo_unit_busy       (busy),
    .o_core_amo_unit_done       (done),
    .o_core_amo_unit_result     (result),
    .o_core_amo_unit_misaligned (misaligned),
    .o_core_amo_unit_req        (req),
    .i_core_amo_unit_gnt        (gnt),
    .o_core_amo_unit_we         (we),
    .o_core_amo_unit_maddr      (maddr),
    .o_core_amo_unit_wdata      (wdata),
    .o_core_amo_unit_msize      (msize),
    .i_core_amo_unit_rvalid     (rvalid),
    .i_core_amo_unit_rdata      (rdata),
    .i_core_amo_unit_snoop_valid(snoop_valid),
    .i_core_amo_unit_snoop_addr (snoop_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] result;
    logic        mis;
    int          lat;
    int          acc;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  exp_t  cur;
  string cur_tag;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [63:0] mem [logic [63:0]];
  logic        s_req, s_we;
  logic [63:0] s_addr, s_wdata;
  int          req_cycles = 0;
  int          wr_count = 0;
  logic [63:0] last_waddr = '0;
  logic [63:0] last_wdata = '0;

  always @(posedge clk) cyc++;

  // Memory model: requests sampled mid-cycle, granted at once, answered one cycle later.
  always @(negedge clk) begin
    s_req   = req && gnt;
    s_we    = we;
    s_addr  = maddr;
    s_wdata = wdata;
  end

  always @(posedge clk) begin
    rvalid <= 1'b0;
    if (s_req) begin
      req_cycles++;
      rvalid <= 1'b1;
      if (s_we) begin
        mem[s_addr] = s_wdata;
        last_waddr  = s_addr;
        last_wdata  = s_wdata;
        wr_count++;
        rdata <= '0;
      end else begin
        rdata <= mem.exists(s_addr) ? mem[s_addr] : 64'h0;
      end
    end
  end

  always @(negedge clk) begin
    if (done) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("[TB] FAIL unexpected_done observed=done required=no_done");
      end
      if (exp_q.size() != 0) begin
        cur     = exp_q.pop_front();
        cur_tag = tag_q.pop_front();
        n_cmp += 3;
        assert (result === cur.result) else begin
          n_err++;
          $error("[TB] FAIL %s.result observed=%h expected=%h", cur_tag, result, cur.result);
        end
        assert (misaligned === cur.mis) else begin
          n_err++;
          $error("[TB] FAIL %s.misaligned observed=%b expected=%b", cur_tag, misaligned, cur.mis);
        end
        assert ((cyc - cur.acc) == cur.lat) else begin
          n_err++;
          $error("[TB] FAIL %s.latency observed=%0d expected=%0d", cur_tag, cyc - cur.acc, cur.lat);
        end
      end
    end
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_start(input logic a, input logic [3:0] op, input logic l, input logic s,
                             input logic [1:0] sz, input logic [63:0] ad, input logic [63:0] sr);
    @(negedge clk);
    amo = a; amo_op = op; lr = l; sc = s; size = sz; addr = ad; src = sr;
    start = 1'b1;
  endtask

  task automatic expect_done(input string tag, input logic [63:0] res, input logic mis, input int lat);
    exp_t e;
    e.result = res;
    e.mis    = mis;
    e.lat    = lat;
    e.acc    = cyc;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_err++;
      $error("[TB] FAIL %s.timeout observed=pending required=done", tag);
      exp_q.delete();
      tag_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input string tag, input logic a, input logic [3:0] op,
                                input logic l, input logic s, input logic [1:0] sz,
                                input logic [63:0] ad, input logic [63:0] sr,
                                input logic [63:0] res, input logic mis, input int lat);
    drive_start(a, op, l, s, sz, ad, sr);
    expect_done(tag, res, mis, lat);
    @(negedge clk);
    start = 1'b0;
    wait_idle(tag);
  endtask

  task automatic pulse_snoop(input logic [63:0] ad);
    @(negedge clk);
    snoop_valid = 1'b1;
    snoop_addr  = ad;
    @(negedge clk);
    snoop_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int reqs_before;
    int wr_before;
    rst = 1'b1; start = 1'b0; amo = 1'b0; amo_op = 4'd0; lr = 1'b0; sc = 1'b0;
    size = 2'b11; addr = '0; src = '0; gnt = 1'b1; snoop_valid = 1'b0; snoop_addr = '0;
    mem[64'h100] = 64'd5;
    mem[64'h40]  = 64'h0000_0000_FFFF_FFFF;
    mem[64'h50]  = 64'h0000_0000_8000_0000;
    mem[64'h200] = 64'd7;
    mem[64'h300] = 64'h11;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("reset.busy", {63'd0, busy}, 64'd0);
    check_output("reset.done", {63'd0, done}, 64'd0);
    check_output("reset.req", {63'd0, req}, 64'd0);
    check_output("reset.we", {63'd0, we}, 64'd0);
    check_output("reset.misaligned", {63'd0, misaligned}, 64'd0);
    check_output("reset.result", result, 64'd0);
    check_output("reset.maddr", maddr, 64'd0);
    check_output("reset.wdata", wdata, 64'd0);

    apply_stimulus("amoadd_d", 1, 4'd1, 0, 0, 2'b11, 64'h100, 64'd3, 64'd5, 0, 5);
    check_output("amoadd_d.waddr", last_waddr, 64'h100);
    check_output("amoadd_d.mem", mem[64'h100], 64'd8);

    apply_stimulus("amomin_w", 1, 4'd5, 0, 0, 2'b10, 64'h40, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 5);
    check_output("amomin_w.wdata", {32'd0, last_wdata[31:0]}, 64'hFFFF_FFFF);

    apply_stimulus("amomaxu_w", 1, 4'd8, 0, 0, 2'b10, 64'h50, 64'd1, 64'hFFFF_FFFF_8000_0000, 0, 5);
    check_output("amomaxu_w.wdata", {32'd0, last_wdata[31:0]}, 64'h8000_0000);

    apply_stimulus("lr_d", 0, 4'd0, 1, 0, 2'b11, 64'h200, 64'd0, 64'd7, 0, 3);
    apply_stimulus("sc_d_ok", 0, 4'd0, 0, 1, 2'b11, 64'h200, 64'hAB, 64'd0, 0, 3);
    check_output("sc_d_ok.mem", mem[64'h200], 64'hAB);

    reqs_before = req_cycles;
    apply_stimulus("sc_d_again", 0, 4'd0, 0, 1, 2'b11, 64'h200, 64'hEE, 64'd1, 0, 1);
    check_output("sc_d_again.no_req", 64'(req_cycles), 64'(reqs_before));

    apply_stimulus("lr_d_snoop_hit", 0, 4'd0, 1, 0, 2'b11, 64'h200, 64'd0, 64'hAB, 0, 3);
    pulse_snoop(64'h204);
    wr_before = wr_count;
    apply_stimulus("sc_d_snooped", 0, 4'd0, 0, 1, 2'b11, 64'h200, 64'hCD, 64'd1, 0, 1);
    check_output("sc_d_snooped.no_write", 64'(wr_count), 64'(wr_before));

    apply_stimulus("lr_d_snoop_miss", 0, 4'd0, 1, 0, 2'b11, 64'h200, 64'd0, 64'hAB, 0, 3);
    pulse_snoop(64'h208);
    apply_stimulus("sc_d_other_gran", 0, 4'd0, 0, 1, 2'b11, 64'h200, 64'hCD, 64'd0, 0, 3);
    check_output("sc_d_other_gran.mem", mem[64'h200], 64'hCD);

    reqs_before = req_cycles;
    drive_start(1, 4'd0, 0, 0, 2'b10, 64'h102, 64'h55);
    expect_done("amoswap_w_mis", 64'd0, 1, 1);
    #1;
    check_output("amoswap_w_mis.busy_accept", {63'd0, busy}, 64'd1);
    @(negedge clk);
    start = 1'b0;
    #1;
    check_output("amoswap_w_mis.busy_done", {63'd0, busy}, 64'd0);
    wait_idle("amoswap_w_mis");
    check_output("amoswap_w_mis.no_req", 64'(req_cycles), 64'(reqs_before));

    apply_stimulus("lr_d_300", 0, 4'd0, 1, 0, 2'b11, 64'h300, 64'd0, 64'h11, 0, 3);
    drive_start(1, 4'd4, 0, 0, 2'b11, 64'h300, 64'h100);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_output("amoor_d.wr_req", {62'd0, req, we}, 64'd3);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_output("amoor_d.rst_req", {63'd0, req}, 64'd0);
    check_output("amoor_d.rst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    apply_stimulus("sc_d_after_rst", 0, 4'd0, 0, 1, 2'b11, 64'h300, 64'h77, 64'd1, 0, 1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
